// File: rtl/axis_pkg.sv
// Shared definitions for the 8-bit AXI-Stream packet generator: data and
// counter widths, the generator FSM state type and a counter-width helper.
package axis_pkg;

    localparam int AXIS_DATA_W = 8;
    localparam int PKT_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } pkt_state_e;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int ctr_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/axis_beat_ctr.sv
// Loadable down-counter used for remaining-beat tracking and for the
// inter-packet gap countdown. Decrements saturate at zero.
module axis_beat_ctr
    import axis_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_in,
    input  logic [W-1:0] load_val_in,
    input  logic         dec_in,
    output logic         last_out,
    output logic         next_last_out,
    output logic         zero_out
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins over a decrement; the count never goes below zero.
    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_val_in;
        end else if (dec_in && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_out      = (count_q == W'(1));
    // Lets the owner register a "last" flag that is aligned with the new count.
    assign next_last_out = (count_d == W'(1));
    assign zero_out      = (count_q == '0);

endmodule

// File: rtl/axis_8bit_pkt_gen.sv
// AXI-Stream 8-bit packet transmitter: on an accepted start it sends a packet
// of len_in beats with incrementing data from base_in, honours backpressure,
// then idles GAP_CYCLES cycles before it accepts the next start.
module axis_8bit_pkt_gen
    import axis_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_in,
    input  logic [LEN_W-1:0]       len_in,
    input  logic [AXIS_DATA_W-1:0] base_in,
    output logic [AXIS_DATA_W-1:0] m_tdata_out,
    output logic                   m_tvalid_out,
    input  logic                   m_tready_in,
    output logic                   m_last_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [PKT_CNT_W-1:0]   pkt_cnt_out
);

    localparam int GAP_W = ctr_width(GAP_CYCLES);

    pkt_state_e             state_q, state_d;
    logic [AXIS_DATA_W-1:0] tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [PKT_CNT_W-1:0]   cnt_q, cnt_d;

    logic beat_load, beat_dec, beat_last, beat_next_last, beat_zero;
    logic gap_load, gap_dec, gap_last, gap_next_last, gap_zero;
    logic unused_gap_next_last;
    logic xfer;

    assign xfer = tvalid_q & m_tready_in;
    assign unused_gap_next_last = gap_next_last;

    axis_beat_ctr #(.W(LEN_W)) u_beat_ctr (
        .clk           (clk),
        .rst           (rst),
        .load_in       (beat_load),
        .load_val_in   (len_in),
        .dec_in        (beat_dec),
        .last_out      (beat_last),
        .next_last_out (beat_next_last),
        .zero_out      (beat_zero)
    );

    axis_beat_ctr #(.W(GAP_W)) u_gap_ctr (
        .clk           (clk),
        .rst           (rst),
        .load_in       (gap_load),
        .load_val_in   (GAP_W'(GAP_CYCLES)),
        .dec_in        (gap_dec),
        .last_out      (gap_last),
        .next_last_out (gap_next_last),
        .zero_out      (gap_zero)
    );

    // Next-state and next-output logic; every output is computed here and registered.
    always_comb begin
        state_d   = state_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        beat_load = 1'b0;
        beat_dec  = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_in && (len_in != '0)) begin
                    state_d   = ST_SEND;
                    beat_load = 1'b1;
                    tdata_d   = base_in;
                    tvalid_d  = 1'b1;
                    last_d    = beat_next_last;
                end
            end
            ST_SEND: begin
                if (beat_zero) begin
                    // Unreachable in normal operation; recovers a corrupted count.
                    state_d  = ST_IDLE;
                    tvalid_d = 1'b0;
                    last_d   = 1'b0;
                end else if (xfer) begin
                    beat_dec = 1'b1;
                    tdata_d  = tdata_q + 8'd1;
                    last_d   = beat_next_last;
                    if (beat_last) begin
                        tvalid_d = 1'b0;
                        last_d   = 1'b0;
                        done_d   = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d  = ST_GAP;
                            gap_load = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_dec = 1'b1;
                if (gap_last || gap_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                last_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_tdata_out  = tdata_q;
    assign m_tvalid_out = tvalid_q;
    assign m_last_out   = last_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign pkt_cnt_out  = cnt_q;

endmodule

// File: tb/tb_axis_8bit_pkt_gen.sv
// Self-checking bench for axis_8bit_pkt_gen: directed packets plus randomized
// lengths, bases, backpressure and stray starts, against a beat-index model.
module tb_axis_8bit_pkt_gen;

    localparam int LEN_W = 8;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_in = 1'b0;
    logic [LEN_W-1:0] len_in = '0;
    logic [7:0]       base_in = '0;
    logic             m_tready_in = 1'b0;
    logic [7:0]       m_tdata_out;
    logic             m_tvalid_out;
    logic             m_last_out;
    logic             busy_out;
    logic             done_out;
    logic [15:0]      pkt_cnt_out;

    int n_vec   = 0;
    int n_err   = 0;
    int exp_cnt = 0;

    axis_8bit_pkt_gen #(.LEN_W(LEN_W), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_in     (start_in),
        .len_in       (len_in),
        .base_in      (base_in),
        .m_tdata_out  (m_tdata_out),
        .m_tvalid_out (m_tvalid_out),
        .m_tready_in  (m_tready_in),
        .m_last_out   (m_last_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .pkt_cnt_out  (pkt_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_tdata"},  32'(m_tdata_out),  32'd0);
        check_val({tag, "_tvalid"}, 32'(m_tvalid_out), 32'd0);
        check_val({tag, "_last"},   32'(m_last_out),   32'd0);
        check_val({tag, "_busy"},   32'(busy_out),     32'd0);
        check_val({tag, "_done"},   32'(done_out),     32'd0);
        check_val({tag, "_cnt"},    32'(pkt_cnt_out),  32'd0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: three stall cycles on beat index 1.
    task automatic send_pkt(input int len, input logic [7:0] base, input int mode);
        int  i;
        int  guard;
        int  stalls;
        logic r;
        start_in    = 1'b1;
        len_in      = LEN_W'(len);
        base_in     = base;
        m_tready_in = 1'($urandom_range(0, 1));
        tick();
        start_in = 1'b0;
        if (len == 0) begin
            check_val("zero_len_busy",   32'(busy_out),     32'd0);
            check_val("zero_len_tvalid", 32'(m_tvalid_out), 32'd0);
            check_val("zero_len_done",   32'(done_out),     32'd0);
            check_val("zero_len_cnt",    32'(pkt_cnt_out),  32'(exp_cnt));
            return;
        end
        check_val("start_busy", 32'(busy_out), 32'd1);
        i = 0;
        guard = 0;
        stalls = 0;
        while (i < len && guard < 500) begin
            check_val("beat_tvalid", 32'(m_tvalid_out), 32'd1);
            check_val("beat_tdata",  32'(m_tdata_out),  32'(8'(base + 8'(i))));
            check_val("beat_last",   32'(m_last_out),   32'(i == len - 1));
            check_val("beat_done",   32'(done_out),     32'd0);
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                default: r = !(i == 1 && stalls < 3);
            endcase
            if (!r) stalls++;
            m_tready_in = r;
            start_in    = 1'($urandom_range(0, 1));
            tick();
            if (r) i++;
            guard++;
        end
        check_val("beats_sent", 32'(i), 32'(len));
        exp_cnt = (exp_cnt + 1) & 32'hFFFF;
        m_tready_in = 1'($urandom_range(0, 1));
        $display("packet len=%0d base=0x%02h stalls=%0d pkt_cnt=%0d", len, base, stalls, pkt_cnt_out);
        check_val("end_done",   32'(done_out),     32'd1);
        check_val("end_cnt",    32'(pkt_cnt_out),  32'(exp_cnt));
        check_val("end_tvalid", 32'(m_tvalid_out), 32'd0);
        check_val("end_last",   32'(m_last_out),   32'd0);
        check_val("end_busy",   32'(busy_out),     32'(GAP > 0));
        for (int g = 0; g < GAP; g++) begin
            start_in = 1'($urandom_range(0, 1));
            tick();
            check_val("gap_tvalid", 32'(m_tvalid_out), 32'd0);
            check_val("gap_done",   32'(done_out),     32'd0);
            check_val("gap_busy",   32'(busy_out),     32'(g < GAP - 1));
            check_val("gap_cnt",    32'(pkt_cnt_out),  32'(exp_cnt));
        end
        start_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         period;
        logic [7:0] b;
        int         l;

        // Reset state.
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Reset mid-packet: abandon an 8-beat packet after its 2nd beat.
        b = 8'($urandom_range(0, 255));
        start_in = 1'b1;
        len_in = LEN_W'(8);
        base_in = b;
        m_tready_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        check_val("pre_rst_tdata", 32'(m_tdata_out), 32'(8'(b + 8'd2)));
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        $display("reset mid-packet base=0x%02h", b);
        tick();
        rst = 1'b1;
        check_all_zero("rst_release");
        exp_cnt = 0;
        send_pkt(8, 8'($urandom_range(0, 255)), 0);

        // Directed packets.
        send_pkt(4, 8'h02, 0);
        send_pkt(3, 8'h10, 2);
        send_pkt(3, 8'hFE, 0);
        send_pkt(1, 8'h77, 1);
        send_pkt(0, 8'h55, 0);

        // Gap spacing with start held high.
        period = 2 + GAP + 1;
        start_in = 1'b1;
        len_in = LEN_W'(2);
        base_in = 8'h40;
        m_tready_in = 1'b1;
        for (int k = 0; k < 2 * period; k++) begin
            tick();
            check_val("spacing_tvalid", 32'(m_tvalid_out), 32'((k % period) < 2));
            check_val("spacing_done",   32'(done_out),     32'((k % period) == 2));
            if ((k % period) < 2)
                check_val("spacing_tdata", 32'(m_tdata_out), 32'(8'(8'h40 + 8'(k % period))));
        end
        start_in = 1'b0;
        exp_cnt += 2;
        $display("spacing run: two packets, pkt_cnt=%0d", pkt_cnt_out);
        tick();
        check_val("spacing_idle_busy", 32'(busy_out),    32'd0);
        check_val("spacing_cnt",       32'(pkt_cnt_out), 32'(exp_cnt));

        // Randomized packets with random backpressure and stray starts.
        for (int n = 0; n < 30; n++) begin
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            send_pkt(l, 8'($urandom_range(0, 255)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_8bit_pkt_gen.md
# axis_8bit_pkt_gen

AXI-Stream 8-bit packet transmitter. On a start pulse it emits one packet of a programmed beat count with incrementing data on its master port, honouring downstream backpressure, and marks the final beat with `m_last_out`. It drives the slave side of `axis_8bit_reg` or any other 8-bit stream consumer in the datapath, and serves as the traffic source for stream blocks and their benches.

## Interface
- `LEN_W`, default 8: width of the packet-length input; maximum packet is 2^LEN_W − 1 beats.
- `GAP_CYCLES`, default 2: idle cycles inserted after each packet with `m_tvalid_out` low; 0 is legal.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start_in`, input, 1: one-cycle request to send a packet; sampled only in IDLE.
- `len_in`, input, LEN_W: packet length in beats; latched on an accepted start.
- `base_in`, input, 8: data value of the first beat; latched on an accepted start.
- `m_tdata_out`, output, 8: stream data.
- `m_tvalid_out`, output, 1: stream valid.
- `m_tready_in`, input, 1: stream ready from downstream.
- `m_last_out`, output, 1: high on the final beat of a packet.
- `busy_out`, output, 1: high from the accepted start until the return to IDLE.
- `done_out`, output, 1: one-cycle pulse after the last beat transfers.
- `pkt_cnt_out`, output, 16: count of completed packets; wraps from 0xFFFF to 0.

## Operation
- **Registered outputs:** all outputs are registered. Reset value of every output is 0, applied immediately on `rst` low, independent of `clk`.
- **FSM states:**
  - IDLE: `busy_out` = 0, `m_tvalid_out` = 0.
  - IDLE → SEND: on `start_in` = 1 with `len_in` ≠ 0. The block latches `len_in` into a remaining-beat counter and `base_in` into the data register.
  - `start_in` with `len_in` = 0 is ignored: no state change, no `done_out`, no count change.
  - SEND: `m_tvalid_out` = 1. A beat transfers on any edge where `m_tvalid_out` and `m_tready_in` are both 1.
  - On each transfer, data increments modulo 256 (0xFF → 0x00) and the remaining count decrements.
  - `m_last_out` = 1 exactly when the remaining count is 1.
  - SEND → GAP: on transfer of the last beat, or SEND → IDLE if `GAP_CYCLES` = 0.
  - GAP: `m_tvalid_out` = 0 for exactly `GAP_CYCLES` cycles, then IDLE.
- **AXI-Stream rules:**
  - `m_tvalid_out` never depends combinationally on `m_tready_in`.
  - Once asserted, `m_tvalid_out`, `m_tdata_out` and `m_last_out` hold steady until the transfer.
  - `m_tvalid_out` never drops mid-packet.
- **Start while busy:** `start_in` while `busy_out` = 1 is ignored and not queued.
- **Completion:** on the last-beat transfer edge, `done_out` goes high for one cycle and `pkt_cnt_out` increments.
- **Reset mid-packet:** the packet is abandoned with no `done_out` and no count increment. The block resumes in IDLE.

## Timing
- **Start latency:** start sampled at edge N puts `m_tvalid_out` high and the first beat (`base_in`) on the bus after edge N.
- **Throughput:** with `m_tready_in` held high, one beat per cycle. A packet of L beats occupies SEND for L cycles.
- **Completion timing:** `done_out` and the new `pkt_cnt_out` are visible in the cycle after the last transfer edge. In that same cycle the FSM is in GAP, or in IDLE when `GAP_CYCLES` = 0.
- **Earliest next start:** sampled in the first IDLE cycle, which is `GAP_CYCLES` + 1 cycles after the last transfer edge.
- **Backpressure:** `m_tready_in` low holds the current beat indefinitely with no data change.
- **Single-beat packet (L = 1):** the first beat has `m_last_out` = 1.

## Structure
- **Shared package `axis_pkg`:**
  - `AXIS_DATA_W` = 8.
  - The FSM state type (IDLE, SEND, GAP).
  - The packet-count width constant (16).
- **Natural sub-module `axis_beat_ctr`:**
  - Loadable down-counter with a decrement-on-transfer enable.
  - Outputs a `last` flag (count = 1) and a `zero` flag.
  - Reused for the GAP countdown.
- **Integration:** the generator's master port connects directly to `axis_8bit_reg` slave ports in system benches.

## Test plan
- **Basic packet:** `start_in` with `len_in` = 4, `base_in` = 0x02, `m_tready_in` = 1 → beats 0x02, 0x03, 0x04, 0x05 on consecutive cycles; `m_last_out` only on 0x05; `done_out` pulse; `pkt_cnt_out` = 1.
- **Backpressure:** `len_in` = 3, `base_in` = 0x10, `m_tready_in` low for 3 cycles on beat 0x11 → 0x11 and `m_last_out` = 0 held stable with `m_tvalid_out` high; then 0x11, 0x12 transfer; total 3 transfers.
- **Wrap and single beat:**
  - `base_in` = 0xFE, `len_in` = 3 → 0xFE, 0xFF, 0x00.
  - Then `len_in` = 1 → a single beat with `m_last_out` = 1.
- **Ignored starts:**
  - `start_in` during SEND and GAP → no effect on the current packet or `pkt_cnt_out`.
  - `len_in` = 0 start in IDLE → `busy_out` stays 0.
- **Gap spacing:** `GAP_CYCLES` = 2 with `start_in` held high → `m_tvalid_out` low exactly 3 cycles between packets (2 GAP + 1 IDLE).
- **Reset mid-packet:** `rst` low after the 2nd beat of an 8-beat packet → all outputs 0 immediately; `pkt_cnt_out` unchanged at 0; a new start after release sends a full packet from the new `base_in`.
